// File: rtl/gpu_loader_pkg.sv
// Shared types and constants for the boot-time flash to Wishbone loader.
package gpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_WB     = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam int         WB_TIMEOUT   = 256;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: sclk divider, 32-bit transmit shifter (updated on
// falling sclk) and 32-bit receive shifter (sampled on rising sclk).
// Clearing run freezes sclk and the divider so a frame resumes seamlessly.
module spi_shift_engine #(
  parameter int SCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        run,
  input  logic        sdi,
  output logic        sclk,
  output logic        sdo,
  output logic [31:0] rx_data,
  output logic [5:0]  bit_cnt,
  output logic        fall_tick
);

  localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);

  logic [15:0] cnt;
  logic [31:0] tx;
  logic        tick;

  assign tick      = run && (cnt == DIV_LAST);
  assign fall_tick = tick && sclk;

  // Divider, sclk toggle, transmit shift on fall, receive sample on rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tx      <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      tx      <= load_data;
      sdo     <= load_data[31];
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (run) begin
      if (tick) begin
        cnt  <= '0;
        sclk <= ~sclk;
        if (!sclk) begin
          rx_data <= {rx_data[30:0], sdi};
          bit_cnt <= bit_cnt + 6'd1;
        end else begin
          // After the 32nd fall tx is empty, so sdo returns to 0.
          tx  <= {tx[30:0], 1'b0};
          sdo <= tx[30];
          if (bit_cnt == 6'd32) bit_cnt <= '0;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/flash_wb_loader.sv
// Boot loader: SPI flash READ (0x03) stream -> single Wishbone write cycles.
// Optional feature macro FLASH_WB_LOADER_TIMEOUT_EN: abort a Wishbone cycle
// with no ack after WB_TIMEOUT cycles and raise the sticky error flag.
// Wishbone handshake: a write is accepted on the clock edge where
// wb_stb_o and wb_ack_i are both high; stb/cyc drop on the following cycle.
module flash_wb_loader
  import gpu_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter logic [31:0] WB_BASE    = 32'h0,
  parameter int          WORD_COUNT = 16384,
  parameter int          SCLK_DIV   = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdo,
  input  logic        sdi,
  output logic        wp_n,
  output logic        hld_n,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  output logic [2:0]  state_dbg
);

  localparam logic [16:0] WC = 17'(WORD_COUNT);

  state_t      state;
  logic [15:0] idx;
  logic [16:0] idx_inc;
  logic        run, load;
  logic [31:0] rx_data;
  logic [5:0]  bit_cnt;
  logic        fall_tick, frame_done, cmd_done;

  assign wp_n      = 1'b1;
  assign hld_n     = 1'b1;
  assign wb_sel_o  = 4'hf;
  assign state_dbg = state;

  assign idx_inc    = {1'b0, idx} + 17'd1;
  assign run        = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign load       = (state == ST_IDLE) && start && (WC != 17'd0);
  assign frame_done = fall_tick && (bit_cnt == 6'd32);
  assign cmd_done   = fall_tick && (bit_cnt == 6'd8);

  spi_shift_engine #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk       (clk_100MHz),
    .rst_n     (reset_n),
    .load      (load),
    .load_data ({SPI_READ_CMD, FLASH_BASE}),
    .run       (run),
    .sdi       (sdi),
    .sclk      (sclk),
    .sdo       (sdo),
    .rx_data   (rx_data),
    .bit_cnt   (bit_cnt),
    .fall_tick (fall_tick)
  );

`ifdef FLASH_WB_LOADER_TIMEOUT_EN
  logic [8:0] tmo;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Sequencer: header, per-word read, Wishbone write, completion pulse.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
`ifdef FLASH_WB_LOADER_TIMEOUT_EN
      tmo      <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef FLASH_WB_LOADER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            idx <= '0;
            if (WC == 17'd0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_CMD;
              cs_n  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        ST_CMD:  if (cmd_done)   state <= ST_ADDR;
        ST_ADDR: if (frame_done) state <= ST_DATA;
        ST_DATA: begin
          if (frame_done) begin
            state    <= ST_WB;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= word_addr(WB_BASE, idx);
            wb_dat_o <= rx_data;
`ifdef FLASH_WB_LOADER_TIMEOUT_EN
            tmo      <= '0;
`endif
          end
        end
        ST_WB: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            idx      <= idx_inc[15:0];
            if (idx_inc == WC) begin
              state <= ST_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              cs_n  <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
`ifdef FLASH_WB_LOADER_TIMEOUT_EN
          else if (tmo == 9'(WB_TIMEOUT - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            error_q  <= 1'b1;
            state    <= ST_FINISH;
            done     <= 1'b1;
            busy     <= 1'b0;
            cs_n     <= 1'b1;
          end else begin
            tmo <= tmo + 9'd1;
          end
`endif
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
